dlx_dmem_responder: RTL and testbench
=====================================

# dlx_dmem_responder

Data-memory responder for the DLX pipeline: the slave end of the data bus driven by the MEM stage. It accepts one load or store request at a time, inserts a configurable number of wait states, commits stores to a word-addressed RAM, returns load data and pulses `d_data_valid` to release the stalled MEM stage. It sits outside the core, between the MEM-stage bus and the data RAM.

## Interface
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two.
- `LATENCY`, 2: wait states inserted between request acceptance and response; 0..15.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned for out-of-range loads.

- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `d_address` in 32: byte address; word index = `d_address[log2(DEPTH_WORDS)+1:2]`; bits [1:0] ignored.
- `d_data_write` in 32: store data.
- `d_write_enable` in 1: store request.
- `d_load_enable` in 1: load request.
- `d_data_read` out 32: load data; meaningful only while `d_data_valid`.
- `d_data_valid` out 1: one-cycle response pulse for the accepted request (loads and stores).
- `d_error` out 1: asserted with `d_data_valid` when the accepted address is out of range.

## Operation
- States: IDLE, WAIT, RESP (shared enum).
- IDLE: if `d_write_enable | d_load_enable` at an edge, capture address, data and op. Both high: treated as a store; the load is dropped. Next state WAIT with counter = LATENCY, or RESP directly when LATENCY = 0.
- WAIT: counter decrements each edge; on the edge where counter == 1, go to RESP.
- Entering RESP (same edge): store writes RAM; load registers RAM word into `d_data_read`.
- RESP: `d_data_valid` = 1 for exactly one cycle; next state IDLE unconditionally.
- Requests seen in WAIT or RESP are ignored; the requester holds its request stable until `d_data_valid`. A request still present in the IDLE cycle after RESP is a new request.
- Out of range: `d_address[31:log2(DEPTH_WORDS)+2]` nonzero. Store is dropped (RAM unchanged); load returns ERR_DATA; `d_error` = 1 alongside `d_data_valid`.
- Stores leave `d_data_read` unchanged.
- Reset: state IDLE, counter 0, `d_data_valid` 0, `d_error` 0, `d_data_read` 0. RAM contents are not cleared. Reset during WAIT aborts the request: no RAM write, no response.

## Timing
- Request visible in cycle 0 (sampled at end of cycle 0) -> `d_data_valid` high in cycle LATENCY+1.
- Throughput: one request per LATENCY+2 cycles with a continuously asserted request stream.
- Store committed by the start of the valid cycle; a load accepted afterwards observes it.
- `d_data_read`, `d_data_valid`, `d_error` are registered outputs; no combinational path from inputs.

## Structure
- Package `dlx_mem_pkg`: state enum (IDLE/WAIT/RESP), `ERR_DATA` default, word-address width helper.
- Sub-module `dlx_dmem_array`: single-port RAM, synchronous write, synchronous registered read, `DEPTH_WORDS` parameter; the FSM, capture registers, range check and counter stay in the top.

## Test plan
- LATENCY=2: store 32'h1234_5678 at 0x40, then load 0x40 -> valid in cycle 3 of each request, load returns 32'h1234_5678, `d_error` 0.
- LATENCY=0: back-to-back loads at 0x0 and 0x4 held continuously -> valid pulses in cycles 1 and 3, each one cycle wide.
- Both enables high at 0x80 with data 32'hA5A5_A5A5 -> treated as a store; subsequent load of 0x80 returns 32'hA5A5_A5A5.
- DEPTH_WORDS=1024: load 0x1000 -> valid with `d_error` 1, data 32'hDEAD_BEEF; store 0x1000 -> `d_error` 1 and word 0 unchanged.
- Address 0x43 store 32'hCAFE_0001 -> load 0x40 returns 32'hCAFE_0001 (low bits ignored).
- LATENCY=4: reset asserted in cycle 2 of a store to 0x8 -> no valid pulse; a later load of 0x8 returns the prior contents.

Source files
------------

// File: rtl/dlx_mem_pkg.sv
// Shared types and constants for the DLX data-memory responder.
package dlx_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // Selects what d_data_read presents; held across stores.
  typedef enum logic [1:0] {
    SRC_ZERO,
    SRC_RAM,
    SRC_ERR
  } rd_src_t;

  localparam int unsigned CNT_W        = 4;
  localparam logic [31:0] DLX_ERR_DATA = 32'hDEAD_BEEF;

  function automatic int unsigned word_addr_w(input int unsigned depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/dlx_dmem_array.sv
// Word-addressed single-port data RAM: synchronous write, registered read.
module dlx_dmem_array
  import dlx_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  localparam int unsigned AW = word_addr_w(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dlx_dmem_responder.sv
// Slave end of the DLX MEM-stage data bus: one request at a time, LATENCY wait
// states, then a single-cycle d_data_valid pulse that releases the stalled stage.
module dlx_dmem_responder
  import dlx_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] ERR_DATA    = DLX_ERR_DATA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_address,
  input  logic [31:0] d_data_write,
  input  logic        d_write_enable,
  input  logic        d_load_enable,
  output logic [31:0] d_data_read,
  output logic        d_data_valid,
  output logic        d_error
);

  localparam int unsigned AW = word_addr_w(DEPTH_WORDS);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               accept, enter_resp;
  rd_src_t            rd_src;

  logic [31:0]        addr_p0, wdata_p0;
  logic               store_p0;

  logic [31:0]        acc_addr, acc_wdata;
  logic               acc_store, acc_oor;
  logic               ram_we, ram_re;
  logic [31:0]        ram_rdata;
  logic               unused_low_bits;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (d_write_enable | d_load_enable) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_W'(LATENCY);
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt <= CNT_W'(1)) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY = 0 the access happens on the accepting edge, before the
  // capture registers hold the request, so IDLE uses the live bus.
  always_comb begin
    if (state == IDLE) begin
      acc_addr  = d_address;
      acc_wdata = d_data_write;
      acc_store = d_write_enable;
    end else begin
      acc_addr  = addr_p0;
      acc_wdata = wdata_p0;
      acc_store = store_p0;
    end
  end

  assign acc_oor         = |acc_addr[31:AW+2];
  assign unused_low_bits = ^acc_addr[1:0];
  assign ram_we          = enter_resp & acc_store & ~acc_oor & ~reset;
  assign ram_re          = enter_resp & ~acc_store & ~acc_oor & ~reset;

  // Request capture (data only)
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0  <= d_address;
      wdata_p0 <= d_data_write;
      store_p0 <= d_write_enable;
    end
  end

  // Control state and registered response
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      d_data_valid <= 1'b0;
      d_error      <= 1'b0;
      rd_src       <= SRC_ZERO;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      d_data_valid <= enter_resp;
      d_error      <= enter_resp & acc_oor;
      if (enter_resp & ~acc_store) rd_src <= acc_oor ? SRC_ERR : SRC_RAM;
    end
  end

  dlx_dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk  (clk),
    .we   (ram_we),
    .re   (ram_re),
    .addr (acc_addr[AW+1:2]),
    .wdata(acc_wdata),
    .rdata(ram_rdata)
  );

  always_comb begin
    case (rd_src)
      SRC_RAM: d_data_read = ram_rdata;
      SRC_ERR: d_data_read = ERR_DATA;
      default: d_data_read = '0;
    endcase
  end

endmodule

// File: tb/tb_dlx_dmem_responder.sv
// Scoreboard bench for dlx_dmem_responder at LATENCY 2, 0 and 4.
module tb_dlx_dmem_responder;

  localparam int NI = 3;
  localparam int LATS [NI] = '{2, 0, 4};

  logic        clk = 1'b0;
  logic [31:0] addr_s  [NI];
  logic [31:0] wdata_s [NI];
  logic        we_s    [NI];
  logic        le_s    [NI];
  logic        rst_s   [NI];
  logic [31:0] rd_s    [NI];
  logic        vld_s   [NI];
  logic        err_s   [NI];

  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] last_rd [NI];

  typedef struct {
    int          inst;
    int          due;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dlx_dmem_responder #(
      .DEPTH_WORDS(1024),
      .LATENCY    (LATS[g]),
      .ERR_DATA   (32'hDEAD_BEEF)
    ) u_dut (
      .clk           (clk),
      .reset         (rst_s[g]),
      .d_address     (addr_s[g]),
      .d_data_write  (wdata_s[g]),
      .d_write_enable(we_s[g]),
      .d_load_enable (le_s[g]),
      .d_data_read   (rd_s[g]),
      .d_data_valid  (vld_s[g]),
      .d_error       (err_s[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (vld_s[i] === 1'b1) begin
        if (sbq.size() == 0) begin
          check_eq("unexpected_valid", 32'(i), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check_eq("resp_inst", 32'(i), 32'(e.inst));
          check_eq("resp_cycle", 32'(cyc), 32'(e.due));
          check_eq("resp_err", {31'b0, err_s[i]}, {31'b0, e.err});
          check_eq("resp_data", rd_s[i], e.data);
        end
      end
    end
  end

  task automatic wait_valid(input int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (vld_s[i] !== 1'b1 && n < 40);
    check_eq("resp_seen", {31'b0, vld_s[i]}, 32'd1);
  endtask

  task automatic push_exp(input int i, input logic we, input logic le,
                          input logic exp_err, input logic [31:0] exp_rd);
    exp_t e;
    if (le && !we) last_rd[i] = exp_rd;
    e.inst = i;
    e.due  = cyc + LATS[i] + 1;
    e.err  = exp_err;
    e.data = last_rd[i];
    sbq.push_back(e);
  endtask

  task automatic do_req(input int i, input logic we, input logic le, input logic [31:0] a,
                        input logic [31:0] wd, input logic exp_err, input logic [31:0] exp_rd);
    @(posedge clk);
    #1;
    addr_s[i]  = a;
    wdata_s[i] = wd;
    we_s[i]    = we;
    le_s[i]    = le;
    push_exp(i, we, le, exp_err, exp_rd);
    wait_valid(i);
    @(posedge clk);
    #1;
    we_s[i] = 1'b0;
    le_s[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      addr_s[i]  = '0;
      wdata_s[i] = '0;
      we_s[i]    = 1'b0;
      le_s[i]    = 1'b0;
      rst_s[i]   = 1'b1;
      last_rd[i] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check_eq("rst_valid", {31'b0, vld_s[i]}, 32'd0);
      check_eq("rst_error", {31'b0, err_s[i]}, 32'd0);
      check_eq("rst_rdata", rd_s[i], 32'd0);
      rst_s[i] = 1'b0;
    end

    // LATENCY = 2: store/load, dual enable, out of range, low address bits
    do_req(0, 1, 0, 32'h0000_0000, 32'h0BAD_F00D, 0, 0);
    do_req(0, 1, 0, 32'h0000_0040, 32'h1234_5678, 0, 0);
    do_req(0, 0, 1, 32'h0000_0040, 32'h0,         0, 32'h1234_5678);
    do_req(0, 1, 1, 32'h0000_0080, 32'hA5A5_A5A5, 0, 0);
    do_req(0, 0, 1, 32'h0000_0080, 32'h0,         0, 32'hA5A5_A5A5);
    do_req(0, 0, 1, 32'h0000_1000, 32'h0,         1, 32'hDEAD_BEEF);
    do_req(0, 1, 0, 32'h0000_1000, 32'h7777_7777, 1, 0);
    do_req(0, 0, 1, 32'h0000_0000, 32'h0,         0, 32'h0BAD_F00D);
    do_req(0, 1, 0, 32'h0000_0043, 32'hCAFE_0001, 0, 0);
    do_req(0, 0, 1, 32'h0000_0040, 32'h0,         0, 32'hCAFE_0001);

    // LATENCY = 0: two loads with the request held continuously
    do_req(1, 1, 0, 32'h0000_0000, 32'h1111_0000, 0, 0);
    do_req(1, 1, 0, 32'h0000_0004, 32'h2222_0004, 0, 0);
    @(posedge clk);
    #1;
    addr_s[1] = 32'h0000_0000;
    le_s[1]   = 1'b1;
    push_exp(1, 0, 1, 0, 32'h1111_0000);
    wait_valid(1);
    @(posedge clk);
    #1;
    addr_s[1] = 32'h0000_0004;
    push_exp(1, 0, 1, 0, 32'h2222_0004);
    wait_valid(1);
    @(posedge clk);
    #1;
    le_s[1] = 1'b0;
    do_req(1, 0, 1, 32'h0000_1004, 32'h0, 1, 32'hDEAD_BEEF);

    // LATENCY = 4: reset in cycle 2 of a store aborts it
    do_req(2, 1, 0, 32'h0000_0008, 32'h1111_2222, 0, 0);
    do_req(2, 0, 1, 32'h0000_0008, 32'h0,         0, 32'h1111_2222);
    @(posedge clk);
    #1;
    addr_s[2]  = 32'h0000_0008;
    wdata_s[2] = 32'h9999_9999;
    we_s[2]    = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_s[2] = 1'b1;
    @(posedge clk);
    #1;
    rst_s[2]   = 1'b0;
    we_s[2]    = 1'b0;
    last_rd[2] = '0;
    @(negedge clk);
    check_eq("abort_rdata", rd_s[2], 32'd0);
    repeat (10) @(negedge clk);
    do_req(2, 0, 1, 32'h0000_0008, 32'h0, 0, 32'h1111_2222);

    repeat (4) @(negedge clk);
    check_eq("sb_empty", 32'(sbq.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
